// File: rtl/bit_serial_alu_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial ALU.
// No logic; types and constants only.
// Imported by the top and the 1-bit slice.
package bit_serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_NOR   = 3'b010,
        OP_XOR   = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_NAND  = 3'b110,
        OP_PASSA = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_arith(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/bit_serial_alu_slice.sv
// One-bit ALU slice: logic ops, full adder for ADD/SUB, pass-through of a.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module alu_slice_1_bit
    import bit_serial_alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_t  op,
    output logic out,
    output logic cout
);

    always_comb begin
        out  = 1'b0;
        cout = 1'b0;
        case (op)
            OP_AND:   out = a & b;
            OP_OR:    out = a | b;
            OP_NOR:   out = ~(a | b);
            OP_XOR:   out = a ^ b;
            // SUB arrives here with b already inverted and cin preset to 1
            OP_ADD, OP_SUB: begin
                out  = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_NAND:  out = ~(a & b);
            OP_PASSA: out = a;
            default:  out = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one result bit per cycle through a single 1-bit slice, LSB first.
// Latency: result valid WIDTH+1 cycles after the offer cycle; issue interval WIDTH+2.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module bit_serial_alu
    import bit_serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, sh_r, r_next;
    op_t              op_q;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             s_b, s_out, s_cout;

    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign s_b       = (op_q == OP_SUB) ? ~sh_b[0] : sh_b[0];
    assign r_next    = {s_out, sh_r[WIDTH-1:1]};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    alu_slice_1_bit u_slice (
        .a    (sh_a[0]),
        .b    (s_b),
        .cin  (cy),
        .op   (op_q),
        .out  (s_out),
        .cout (s_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            sh_r     <= '0;
            op_q     <= OP_AND;
            cy       <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    sh_a <= a;
                    sh_b <= b;
                    sh_r <= '0;
                    op_q <= op_t'(op);
                    cy   <= (op_t'(op) == OP_SUB);
                    cnt  <= '0;
                end
                RUN: begin
                    sh_a <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b <= {1'b0, sh_b[WIDTH-1:1]};
                    sh_r <= r_next;
                    cy   <= s_cout;
                    cnt  <= cnt + CW'(1);
                    // Final bit: cy still holds the carry into the MSB
                    if (last_bit) begin
                        result   <= r_next;
                        carry    <= is_arith(op_q) & s_cout;
                        overflow <= is_arith(op_q) & (cy ^ s_cout);
                        zero     <= (r_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed self-checking bench for bit_serial_alu at WIDTH=8.
module tb_bit_serial_alu;
    import bit_serial_alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry, zero, overflow;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] top,
                            output int offer);
        a = ta; b = tb_; op = top; in_valid = 1'b1;
        offer = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int offer, output int lat);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        lat = cyc - offer;
    endtask

    task automatic pop;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({in_ready, out_valid, result, carry, zero, overflow} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b res=%h c=%b z=%b v=%b, want rdy=1 vld=0 res=00 c=0 z=0 v=0",
                     in_ready, out_valid, result, carry, zero, overflow);
        end
    endtask

    // Releases reset and offers the op in the same cycle: accepted on the first edge with rst=0
    task automatic test_add_first;
        int offer, lat;
        rst = 1'b0;
        start_op(8'hFF, 8'h01, OP_ADD, offer);
        wait_out(offer, lat);
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++;
            $display("FAIL add_latency: got %0d cycles, want %0d", lat, W + 1);
        end
        n_checks++;
        if ({out_valid, result, carry, zero, overflow} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ff_01: vld=%b res=%h c=%b z=%b v=%b, want vld=1 res=00 c=1 z=1 v=0",
                     out_valid, result, carry, zero, overflow);
        end
        pop();
    endtask

    logic [W-1:0] va [0:9] = '{8'h80, 8'h00, 8'h0F, 8'hA5, 8'hCC, 8'hCC, 8'hCC, 8'h3C, 8'h7F, 8'h05};
    logic [W-1:0] vb [0:9] = '{8'h01, 8'h01, 8'hF0, 8'hFF, 8'hAA, 8'hAA, 8'hAA, 8'hFF, 8'h01, 8'h05};
    logic [2:0]   vo [0:9] = '{3'b101, 3'b101, 3'b010, 3'b011, 3'b000, 3'b001, 3'b110, 3'b111, 3'b100, 3'b101};
    logic [W-1:0] vr [0:9] = '{8'h7F, 8'hFF, 8'h00, 8'h5A, 8'h88, 8'hEE, 8'h77, 8'h3C, 8'h80, 8'h00};
    logic [2:0]   vf [0:9] = '{3'b101, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b110};

    task automatic test_ops;
        int offer, lat;
        for (int i = 0; i < 10; i++) begin
            start_op(va[i], vb[i], vo[i], offer);
            wait_out(offer, lat);
            n_checks++;
            if ({out_valid, result, carry, zero, overflow} !== {1'b1, vr[i], vf[i]}) begin
                n_fail++;
                $display("FAIL op_vec%0d: op=%b a=%h b=%h vld=%b res=%h czv=%b%b%b, want vld=1 res=%h czv=%b",
                         i, vo[i], va[i], vb[i], out_valid, result, carry, zero, overflow, vr[i], vf[i]);
            end
            pop();
        end
    endtask

    task automatic test_hold;
        int offer, lat;
        start_op(8'h12, 8'h34, OP_ADD, offer);
        wait_out(offer, lat);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                a = 8'hFF; b = 8'hFF; op = OP_PASSA; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            n_checks++;
            if ({out_valid, in_ready, result, carry, zero, overflow} !== {1'b1, 1'b0, 8'h46, 3'b000}) begin
                n_fail++;
                $display("FAIL hold_cyc%0d: vld=%b rdy=%b res=%h czv=%b%b%b, want vld=1 rdy=0 res=46 czv=000",
                         k, out_valid, in_ready, result, carry, zero, overflow);
            end
        end
        in_valid = 1'b0;
        pop();
        n_checks++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 8'h46}) begin
            n_fail++;
            $display("FAIL hold_release: vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=46",
                     out_valid, in_ready, result);
        end
    endtask

    task automatic test_reset_mid;
        int offer, lat;
        start_op(8'h55, 8'h55, OP_ADD, offer);
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, result, carry, zero, overflow} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%b vld=%b res=%h czv=%b%b%b, want rdy=1 vld=0 res=00 czv=000",
                     in_ready, out_valid, result, carry, zero, overflow);
        end
        start_op(8'h03, 8'h04, OP_ADD, offer);
        wait_out(offer, lat);
        n_checks++;
        if ({out_valid, result, carry, zero, overflow} !== {1'b1, 8'h07, 3'b000} || lat !== W + 1) begin
            n_fail++;
            $display("FAIL after_reset_add: vld=%b res=%h czv=%b%b%b lat=%0d, want vld=1 res=07 czv=000 lat=%0d",
                     out_valid, result, carry, zero, overflow, lat, W + 1);
        end
        pop();
    endtask

    logic [W-1:0] ba [0:3] = '{8'h10, 8'h20, 8'hF0, 8'h80};
    logic [W-1:0] bb [0:3] = '{8'h20, 8'h30, 8'h0F, 8'h80};
    logic [2:0]   bo [0:3] = '{3'b100, 3'b101, 3'b011, 3'b100};
    logic [W-1:0] br [0:3] = '{8'h30, 8'hF0, 8'hFF, 8'h00};
    logic [2:0]   bf [0:3] = '{3'b000, 3'b000, 3'b000, 3'b111};

    task automatic test_back_to_back;
        int offer [0:3];
        int lat, n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            a = ba[i]; b = bb[i]; op = bo[i]; in_valid = 1'b1;
            offer[i] = cyc;
            tick();
            in_valid = 1'b0;
            wait_out(offer[i], lat);
            n_checks++;
            if ({out_valid, result, carry, zero, overflow} !== {1'b1, br[i], bf[i]}) begin
                n_fail++;
                $display("FAIL b2b_res%0d: vld=%b res=%h czv=%b%b%b, want vld=1 res=%h czv=%b",
                         i, out_valid, result, carry, zero, overflow, br[i], bf[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (offer[i] - offer[i-1] !== W + 2) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, want %0d",
                             i, offer[i] - offer[i-1], W + 2);
                end
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_first();
        test_ops();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
